// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter family (direction/mode encodings,
// per-edge event classification, sizing helper for internal phase registers).
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // What the counter does on a given edge, after priority resolution.
  typedef enum logic [1:0] {
    EV_IDLE = 2'd0,
    EV_LOAD = 2'd1,
    EV_UP   = 2'd2,
    EV_DN   = 2'd3
  } udc_event_e;

  // Bits needed to hold 0..v-1, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    if (v <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(v);
    end
  endfunction

endpackage

// File: rtl/param_updown_counter_prescaler.sv
// udc_prescaler: counts enabled cycles and fires step_o on every PRESCALE-th one.
// Only instantiated when UDC_PRESCALE_EN is defined.
module udc_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);

  localparam int unsigned PW = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  // step_o is combinational so the owning counter steps on the same edge the
  // PRESCALE-th enable is sampled; a clear suppresses the step.
  assign step_o = en_i & ~clr_i & (phase_q == LAST);

  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = {PW{1'b0}};
    end else if (en_i) begin
      if (phase_q == LAST) begin
        phase_d = {PW{1'b0}};
      end else begin
        phase_d = phase_q + {{(PW-1){1'b0}}, 1'b1};
      end
    end else begin
      phase_d = phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= {PW{1'b0}};
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Parametrised up/down modulo counter with load, wrap/saturate, tc pulse and sticky
// ovf/udf flags. Define UDC_PRESCALE_EN to step once per PRESCALE enabled cycles.
module param_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             sat_mode_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             clr_flags_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             udf_o
);

  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_Q    = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   ONE_EXT  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH:0]   ZERO_EXT = {(WIDTH+1){1'b0}};

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             step_s;
  logic             set_ovf_s;
  logic             set_udf_s;
  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   load_ext_s;
  udc_event_e       ev_s;

`ifdef UDC_PRESCALE_EN
  udc_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en_i),
    .clr_i  (load_i),
    .step_o (step_s)
  );
`else
  // Without the prescaler every enabled cycle is a step; PRESCALE only guards sanity.
  localparam logic PRESCALE_OK = (PRESCALE >= 1) ? 1'b1 : 1'b0;
  assign step_s = en_i & PRESCALE_OK;
`endif

  // Bounds are compared in WIDTH+1 bits so a MAX_VAL below 2**WIDTH-1 never relies on rollover.
  assign cnt_ext_s  = {1'b0, count_q};
  assign load_ext_s = {1'b0, load_val_i};

  always_comb begin
    if (load_i) begin
      ev_s = EV_LOAD;
    end else if (step_s) begin
      ev_s = (up_dn_i == DIR_UP) ? EV_UP : EV_DN;
    end else begin
      ev_s = EV_IDLE;
    end
  end

  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    set_ovf_s = 1'b0;
    set_udf_s = 1'b0;
    case (ev_s)
      EV_LOAD: begin
        count_d = (load_ext_s > MAX_EXT) ? MAX_Q : load_val_i;
      end
      EV_UP: begin
        if (cnt_ext_s == MAX_EXT) begin
          tc_d      = 1'b1;
          set_ovf_s = 1'b1;
          count_d   = (sat_mode_i == MODE_SAT) ? MAX_Q : {WIDTH{1'b0}};
        end else begin
          count_d = WIDTH'(cnt_ext_s + ONE_EXT);
        end
      end
      EV_DN: begin
        if (cnt_ext_s == ZERO_EXT) begin
          tc_d      = 1'b1;
          set_udf_s = 1'b1;
          count_d   = (sat_mode_i == MODE_SAT) ? {WIDTH{1'b0}} : MAX_Q;
        end else begin
          count_d = WIDTH'(cnt_ext_s - ONE_EXT);
        end
      end
      EV_IDLE: begin
        count_d = count_q;
      end
      default: begin
        count_d = count_q;
      end
    endcase
    // A set event in the same cycle as clr_flags keeps the flag high.
    ovf_d = set_ovf_s | (ovf_q & ~clr_flags_i);
    udf_d = set_udf_s | (udf_q & ~clr_flags_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign ovf_o   = ovf_q;
  assign udf_o   = udf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Self-checking bench for param_updown_counter (WIDTH=4, MAX_VAL=9): directed scenarios
// plus randomized traffic against an arithmetic reference model checked every cycle.
module tb_param_updown_counter;
  import counter_pkg::*;

  localparam int W    = 4;
  localparam int MAXV = 9;
`ifdef UDC_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic         clk         = 1'b0;
  logic         reset       = 1'b1;
  logic         en_i        = 1'b0;
  logic         up_dn_i     = 1'b1;
  logic         sat_mode_i  = 1'b0;
  logic         load_i      = 1'b0;
  logic [W-1:0] load_val_i  = 4'd0;
  logic         clr_flags_i = 1'b0;
  logic [W-1:0] count_o;
  logic         tc_o;
  logic         ovf_o;
  logic         udf_o;

  param_updown_counter #(
    .WIDTH    (W),
    .MAX_VAL  (MAXV),
    .PRESCALE (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en_i        (en_i),
    .up_dn_i     (up_dn_i),
    .sat_mode_i  (sat_mode_i),
    .load_i      (load_i),
    .load_val_i  (load_val_i),
    .clr_flags_i (clr_flags_i),
    .count_o     (count_o),
    .tc_o        (tc_o),
    .ovf_o       (ovf_o),
    .udf_o       (udf_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    int cnt;
    int ph;
    bit tc;
    bit ovf;
    bit udf;
  } mst_t;

  mst_t m = '0;

  // Reference: modular arithmetic on integers, enabled-cycle phase counted modulo PS.
  function automatic mst_t model_next(mst_t s, bit rst, bit ld, bit e, bit up, bit sat,
                                      bit clr, int lv);
    mst_t n;
    n = s;
    n.tc = 1'b0;
    if (rst) begin
      n = '0;
      return n;
    end
    n.ovf = s.ovf && !clr;
    n.udf = s.udf && !clr;
    if (ld) begin
      n.cnt = (lv > MAXV) ? MAXV : lv;
      n.ph  = 0;
    end else if (e) begin
      n.ph = (s.ph + 1) % PS;
      if (n.ph == 0) begin
        if (up) begin
          if (s.cnt == MAXV) begin
            n.tc  = 1'b1;
            n.ovf = 1'b1;
          end
          n.cnt = (sat && s.cnt == MAXV) ? MAXV : (s.cnt + 1) % (MAXV + 1);
        end else begin
          if (s.cnt == 0) begin
            n.tc  = 1'b1;
            n.udf = 1'b1;
          end
          n.cnt = (sat && s.cnt == 0) ? 0 : (s.cnt + MAXV) % (MAXV + 1);
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= model_next(m, reset, load_i, en_i, up_dn_i == DIR_UP, sat_mode_i == MODE_SAT,
                    clr_flags_i, int'(load_val_i));
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_count", int'(count_o), m.cnt);
      chk("cyc_tc", int'(tc_o), int'(m.tc));
      chk("cyc_ovf", int'(ovf_o), int'(m.ovf));
      chk("cyc_udf", int'(udf_o), int'(m.udf));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_count(input string name, input int exp);
    chk({name, "_dut"}, int'(count_o), exp);
    chk({name, "_model"}, m.cnt, exp);
  endtask

  int t2_exp[5] = '{2, 1, 0, 0, 0};
`ifdef UDC_PRESCALE_EN
  int t6a_exp[8] = '{0, 0, 0, 1, 1, 1, 1, 2};
  int t6b_exp[7] = '{2, 2, 2, 2, 2, 2, 3};
  int t6c_exp[4] = '{0, 0, 0, 1};
`endif

  initial begin
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    lit_count("rst_count", 0);
    chk("rst_tc", int'(tc_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    chk("rst_udf", int'(udf_o), 0);

    // Wrap up through the terminal value.
    en_i = 1'b1; up_dn_i = DIR_UP; sat_mode_i = MODE_WRAP;
    for (int i = 0; i < 12 * PS; i++) begin
      tick();
      if ((i % PS) == PS - 1) begin
        lit_count("t1_count", (i / PS + 1) % 10);
        chk("t1_tc", int'(tc_o), (i / PS == 9) ? 1 : 0);
      end
    end
    chk("t1_ovf", int'(ovf_o), 1);
    chk("t1_udf", int'(udf_o), 0);

    // Saturating down-count from 3.
    en_i = 1'b0; load_i = 1'b1; load_val_i = 4'd3;
    tick();
    load_i = 1'b0; en_i = 1'b1; up_dn_i = DIR_DN; sat_mode_i = MODE_SAT;
    for (int i = 0; i < 5 * PS; i++) begin
      tick();
      if ((i % PS) == PS - 1) begin
        lit_count("t2_count", t2_exp[i / PS]);
        chk("t2_tc", int'(tc_o), (i / PS >= 3) ? 1 : 0);
      end
    end
    chk("t2_udf", int'(udf_o), 1);

    // Load clamps to MAX_VAL; load beats en.
    en_i = 1'b0; load_i = 1'b1; load_val_i = 4'd15;
    tick();
    lit_count("t3_clamp", 9);
    load_val_i = 4'd4; en_i = 1'b1; up_dn_i = DIR_UP;
    tick();
    lit_count("t3_ldwin", 4);
    chk("t3_tc", int'(tc_o), 0);

    // Set beats clear at the bound; clear alone then works.
    en_i = 1'b0; load_i = 1'b1; load_val_i = 4'd9;
    tick();
    load_i = 1'b0; en_i = 1'b1; up_dn_i = DIR_UP; sat_mode_i = MODE_WRAP; clr_flags_i = 1'b1;
    for (int i = 0; i < PS; i++) tick();
    chk("t4_ovf_set", int'(ovf_o), 1);
    chk("t4_tc", int'(tc_o), 1);
    en_i = 1'b0;
    tick();
    chk("t4_ovf_clr", int'(ovf_o), 0);
    chk("t4_udf_clr", int'(udf_o), 0);
    clr_flags_i = 1'b0;

    // Reset wins over en and load.
    load_i = 1'b1; load_val_i = 4'd9;
    tick();
    load_i = 1'b0; en_i = 1'b1; up_dn_i = DIR_DN;
    for (int i = 0; i < 10 * PS; i++) tick();
    load_i = 1'b1; load_val_i = 4'd5; en_i = 1'b0;
    tick();
    lit_count("t5_pre", 5);
    chk("t5_pre_udf", int'(udf_o), 1);
    reset = 1'b1; en_i = 1'b1; load_i = 1'b1; load_val_i = 4'd7;
    tick();
    reset = 1'b0; en_i = 1'b0; load_i = 1'b0;
    lit_count("t5_count", 0);
    chk("t5_tc", int'(tc_o), 0);
    chk("t5_ovf", int'(ovf_o), 0);
    chk("t5_udf", int'(udf_o), 0);

`ifdef UDC_PRESCALE_EN
    // Prescaler phase: stepping every 4th enabled cycle, en=0 holds, load clears.
    en_i = 1'b1; up_dn_i = DIR_UP; sat_mode_i = MODE_WRAP;
    for (int i = 0; i < 8; i++) begin
      tick();
      lit_count("t6a", t6a_exp[i]);
    end
    for (int i = 0; i < 7; i++) begin
      en_i = (i >= 2 && i <= 4) ? 1'b0 : 1'b1;
      tick();
      lit_count("t6b", t6b_exp[i]);
    end
    en_i = 1'b1;
    tick();
    load_i = 1'b1; load_val_i = 4'd0;
    tick();
    load_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      lit_count("t6c", t6c_exp[i]);
    end
`endif

    // Randomized traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 800; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      load_i      = ($urandom_range(0, 11) == 0);
      en_i        = ($urandom_range(0, 3) != 0);
      up_dn_i     = ($urandom_range(0, 99) < 60) ? DIR_UP : DIR_DN;
      sat_mode_i  = ($urandom_range(0, 1) == 1) ? MODE_SAT : MODE_WRAP;
      clr_flags_i = ($urandom_range(0, 9) == 0);
      load_val_i  = 4'($urandom_range(0, 15));
      tick();
    end
    reset = 1'b0; load_i = 1'b0; en_i = 1'b0; clr_flags_i = 1'b0;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
